// File: rtl/opb_register_simulink2ppc_fifo.sv
// OPB slave readback register: user fabric pushes 32-bit words into a small FIFO,
// the PPC drains it through DATA, monitors it through STATUS and flushes/clears via CTRL.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a decoded OPB hit
// ACK   | one-cycle transfer acknowledge, read data driven on Sl_DBus
module opb_register_simulink2ppc_fifo #(
    parameter logic [31:0] C_BASEADDR   = 32'h01004A00,
    parameter logic [31:0] C_HIGHADDR   = 32'h01004AFF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex5",
    parameter int          C_DEPTH_LOG2 = 2
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
    input  logic                        OPB_RNW,
    input  logic                        OPB_select,
    input  logic                        OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
    output logic                        Sl_xferAck,
    output logic                        Sl_errAck,
    output logic                        Sl_retry,
    output logic                        Sl_toutSup,
    input  logic [31:0]                 user_data_in,
    input  logic                        user_valid,
    output logic                        user_full
);

    localparam int                      DEPTH    = 1 << C_DEPTH_LOG2;
    localparam logic [C_DEPTH_LOG2:0]   FILL_MAX = {1'b1, {C_DEPTH_LOG2{1'b0}}};
    localparam logic [C_DEPTH_LOG2:0]   FILL_ONE = (C_DEPTH_LOG2+1)'(1);
    localparam logic [C_DEPTH_LOG2-1:0] PTR_ONE  = C_DEPTH_LOG2'(1);

    typedef enum logic {S_IDLE, S_ACK} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [31:0]             r_mem [DEPTH];
    logic [C_DEPTH_LOG2-1:0] r_wr_ptr;
    logic [C_DEPTH_LOG2-1:0] r_rd_ptr;
    logic [C_DEPTH_LOG2:0]   r_fill;
    logic [C_DEPTH_LOG2:0]   w_fill_nxt;
    logic                    r_overflow;
    logic [15:0]             r_drop_cnt;
    logic [31:0]             r_rdata;
    logic [31:0]             w_rdata_nxt;
    logic                    r_full;

    logic                    w_in_range;
    logic                    w_hit;
    logic [1:0]              w_off;
    logic                    w_ctrl;
    logic                    w_flush;
    logic                    w_clear;
    logic                    w_fifo_full;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_drop;
    logic [31:0]             w_status;
    logic                    w_unused;

    assign w_in_range = (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
    assign w_hit      = OPB_select && w_in_range && (r_state == S_IDLE);
    assign w_off      = OPB_ABus[28:29];

    assign w_ctrl  = w_hit && !OPB_RNW && (w_off == 2'd2) && OPB_BE[3];
    assign w_flush = w_ctrl && OPB_DBus[31];
    assign w_clear = w_ctrl && OPB_DBus[30];

    // A pop on the hit edge frees the slot a same-cycle push needs; flush overrides both.
    assign w_fifo_full = (r_fill == FILL_MAX);
    assign w_pop       = w_hit && OPB_RNW && (w_off == 2'd0) && (r_fill != '0);
    assign w_push      = user_valid && !w_flush && (!w_fifo_full || w_pop);
    assign w_drop      = user_valid && !w_flush && w_fifo_full && !w_pop;

    assign w_status = {r_drop_cnt, 7'd0, r_overflow, 8'(r_fill)};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_hit) w_state_nxt = S_ACK;
            S_ACK:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_rdata_nxt = '0;
        if (w_hit && OPB_RNW) begin
            case (w_off)
                2'd0:    if (r_fill != '0) w_rdata_nxt = r_mem[r_rd_ptr];
                2'd1:    w_rdata_nxt = w_status;
                default: w_rdata_nxt = '0;
            endcase
        end
    end

    always_comb begin
        w_fill_nxt = r_fill;
        if (w_flush)
            w_fill_nxt = '0;
        else if (w_push && !w_pop)
            w_fill_nxt = r_fill + FILL_ONE;
        else if (w_pop && !w_push)
            w_fill_nxt = r_fill - FILL_ONE;
    end

    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst_n) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
            r_rdata    <= '0;
            r_full     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rdata <= w_rdata_nxt;
            r_fill  <= w_fill_nxt;
            r_full  <= (w_fill_nxt == FILL_MAX);
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            // Clear beats a coincident drop so software sees a clean slate.
            if (w_clear) begin
                r_overflow <= 1'b0;
                r_drop_cnt <= '0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge OPB_Clk) begin
        if (w_push) r_mem[r_wr_ptr] <= user_data_in;
    end

    assign Sl_DBus    = r_rdata;
    assign Sl_xferAck = (r_state == S_ACK);
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign user_full  = r_full;

    assign w_unused = ^{OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:29], (C_FAMILY == "")};

endmodule

// File: tb/tb_opb_register_simulink2ppc_fifo.sv
// Bench for the OPB readback FIFO register: table of push/read/write steps with a
// read-data scoreboard, plus hand-written sequences for the multi-cycle corner cases.
module tb_opb_register_simulink2ppc_fifo;

    localparam logic [31:0] BASE = 32'h01004A00;
    localparam int K_PUSH = 0, K_READ = 1, K_WRITE = 2, K_FULL = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [0:31] abus;
    logic [0:3]  be;
    logic [0:31] dbus;
    logic        rnw;
    logic        sel;
    logic        seqaddr;
    logic [0:31] sl_dbus;
    logic        ack, err_ack, retry, tout;
    logic [31:0] user_data;
    logic        user_valid;
    logic        user_full;

    int          n_cmp = 0;
    int          n_err = 0;
    logic        mon_en = 1'b0;
    logic [31:0] exp_q[$];

    typedef struct {
        int          kind;
        logic [31:0] off;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    opb_register_simulink2ppc_fifo dut (
        .OPB_Clk      (clk),
        .OPB_Rst_n    (rst_n),
        .OPB_ABus     (abus),
        .OPB_BE       (be),
        .OPB_DBus     (dbus),
        .OPB_RNW      (rnw),
        .OPB_select   (sel),
        .OPB_seqAddr  (seqaddr),
        .Sl_DBus      (sl_dbus),
        .Sl_xferAck   (ack),
        .Sl_errAck    (err_ack),
        .Sl_retry     (retry),
        .Sl_toutSup   (tout),
        .user_data_in (user_data),
        .user_valid   (user_valid),
        .user_full    (user_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // Outside the ack cycle the read bus must be quiet and the tie-offs must stay low.
    always @(negedge clk) begin
        if (mon_en && !ack)
            check("idle_bus", {sl_dbus[1:31], err_ack | retry | tout}, 32'h0);
    end

    task automatic add(input int k, input logic [31:0] off, input logic [3:0] b,
                       input logic [31:0] wd, input logic [31:0] exp);
        vec_t v;
        v.kind = k; v.off = off; v.be = b; v.wd = wd; v.exp = exp;
        vecs.push_back(v);
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic push_word(input logic [31:0] d);
        user_data  = d;
        user_valid = 1'b1;
        @(posedge clk); #1;
        user_valid = 1'b0;
    endtask

    task automatic bus_op(input logic [31:0] off, input logic rnw_i, input logic [3:0] be_i,
                          input logic [31:0] wd, input logic [31:0] exp,
                          input logic pv, input logic [31:0] pd, input string nm);
        abus = BASE + off; rnw = rnw_i; be = be_i; dbus = wd; sel = 1'b1;
        user_valid = pv; user_data = pd;
        if (rnw_i) exp_q.push_back(exp);
        check({nm, "_preack"}, {31'd0, ack}, 32'd0);
        @(posedge clk); #1;
        sel = 1'b0; abus = '0; dbus = '0; user_valid = 1'b0;
        check({nm, "_ack"}, {31'd0, ack}, 32'd1);
        if (rnw_i) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL %s: scoreboard empty at ack", nm);
            end else begin
                check({nm, "_data"}, sl_dbus, exp_q.pop_front());
            end
        end
        @(posedge clk); #1;
        check({nm, "_ackdrop"}, {31'd0, ack}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; abus = '0; be = '0; dbus = '0; rnw = 1'b0; sel = 1'b0;
        seqaddr = 1'b0; user_data = '0; user_valid = 1'b0;

        add(K_PUSH,  0,   4'b0000, 32'h11111111, 0);
        add(K_PUSH,  0,   4'b0000, 32'h22222222, 0);
        add(K_READ,  0,   4'b1111, 0, 32'h11111111);
        add(K_READ,  0,   4'b1111, 0, 32'h22222222);
        add(K_READ,  0,   4'b1111, 0, 32'h00000000);
        add(K_READ,  4,   4'b1111, 0, 32'h00000000);
        for (int i = 1; i <= 6; i++) add(K_PUSH, 0, 4'b0000, 32'hA0A0A000 + i, 0);
        add(K_READ,  4,   4'b1111, 0, 32'h00020104);
        add(K_FULL,  0,   4'b0000, 0, 32'h1);
        for (int i = 1; i <= 4; i++) add(K_READ, 0, 4'b1111, 0, 32'hA0A0A000 + i);
        add(K_READ,  4,   4'b1111, 0, 32'h00020100);
        add(K_FULL,  0,   4'b0000, 0, 32'h0);
        add(K_READ,  8,   4'b1111, 0, 32'h00000000);
        add(K_READ,  12,  4'b1111, 0, 32'h00000000);
        add(K_WRITE, 0,   4'b1111, 32'hDEADBEEF, 0);
        add(K_WRITE, 8,   4'b1110, 32'h00000003, 0);
        add(K_READ,  4,   4'b1111, 0, 32'h00020100);
        add(K_WRITE, 8,   4'b0001, 32'h00000003, 0);
        add(K_READ,  4,   4'b1111, 0, 32'h00000000);

        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        check("rst_outputs", {sl_dbus[0:28], ack, user_full, err_ack | retry | tout}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].kind)
                K_PUSH:  push_word(vecs[i].wd);
                K_READ:  bus_op(vecs[i].off, 1'b1, vecs[i].be, 0, vecs[i].exp, 1'b0, 0,
                                $sformatf("vec%0d", i));
                K_WRITE: bus_op(vecs[i].off, 1'b0, vecs[i].be, vecs[i].wd, 0, 1'b0, 0,
                                $sformatf("vec%0d", i));
                default: check($sformatf("vec%0d_full", i), {31'd0, user_full}, vecs[i].exp);
            endcase
        end

        // Full FIFO: push coinciding with a DATA pop is accepted without a drop.
        for (int i = 1; i <= 4; i++) push_word(32'hB0B0B000 + i);
        check("full_before_pp", {31'd0, user_full}, 32'd1);
        bus_op(0, 1'b1, 4'b1111, 0, 32'hB0B0B001, 1'b1, 32'hB0B0B005, "pp_pop");
        bus_op(4, 1'b1, 4'b1111, 0, 32'h00000004, 1'b0, 0, "pp_status");
        check("full_after_pp", {31'd0, user_full}, 32'd1);
        for (int i = 2; i <= 5; i++)
            bus_op(0, 1'b1, 4'b1111, 0, 32'hB0B0B000 + i, 1'b0, 0, $sformatf("pp_drain%0d", i));

        // Flush of a full FIFO with a coincident push: nothing kept, nothing counted.
        for (int i = 1; i <= 4; i++) push_word(32'hC0C0C000 + i);
        bus_op(8, 1'b0, 4'b0001, 32'h00000001, 0, 1'b1, 32'hC0C0C005, "flush_wr");
        bus_op(4, 1'b1, 4'b1111, 0, 32'h00000000, 1'b0, 0, "flush_status");
        bus_op(0, 1'b1, 4'b1111, 0, 32'h00000000, 1'b0, 0, "flush_data");
        check("flush_full", {31'd0, user_full}, 32'd0);

        // Select held through the ack cycle must not produce a second ack.
        abus = BASE + 4; rnw = 1'b1; be = 4'b1111; sel = 1'b1;
        @(posedge clk); #1;
        check("hold_ack1", {31'd0, ack}, 32'd1);
        @(posedge clk); #1;
        check("hold_ack2", {31'd0, ack}, 32'd0);
        sel = 1'b0;

        // Addresses just outside the window are not acknowledged.
        abus = BASE + 32'h100; sel = 1'b1;
        @(posedge clk); #1;
        check("oor_high", {31'd0, ack}, 32'd0);
        abus = BASE - 32'h4;
        @(posedge clk); #1;
        check("oor_low", {31'd0, ack}, 32'd0);
        sel = 1'b0;

        // Reset in the hit cycle aborts the access and clears the fill level.
        push_word(32'hD0D0D001);
        abus = BASE + 4; rnw = 1'b1; sel = 1'b1; rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_hit_ack", {31'd0, ack}, 32'd0);
        rst_n = 1'b1; sel = 1'b0;
        @(posedge clk); #1;
        check("rst_hit_ack2", {31'd0, ack}, 32'd0);
        bus_op(4, 1'b1, 4'b1111, 0, 32'h00000000, 1'b0, 0, "rst_status");

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
